// File: rtl/vec_simd_engine_pkg.sv
// Shared types and helpers for the vector SIMD engine.
//   vec_op_t    : element-wise opcode (COPY aliases NOP)
//   vec_state_t : command FSM states
//   sat_signed  : clamp a wide signed value into a dw-bit two's complement range
//   is_binary   : opcodes that consume operand B
//   low_mask    : k low bits set, or all ones when k == 0
package vec_simd_engine_pkg;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ADD   = 3'd1,
    OP_MUL   = 3'd2,
    OP_SUB   = 3'd3,
    OP_SCALE = 3'd4,
    OP_CLAMP = 3'd5,
    OP_MAX   = 3'd6,
    OP_RELU  = 3'd7
  } vec_op_t;

  localparam vec_op_t OP_COPY = OP_NOP;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } vec_state_t;

  function automatic logic signed [31:0] sat_signed(input logic signed [31:0] v,
                                                    input int unsigned dw);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (dw - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (dw - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic is_binary(input vec_op_t op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_MAX);
  endfunction

  function automatic logic [31:0] low_mask(input int unsigned k);
    if (k == 0) return '1;
    return (32'd1 << k) - 32'd1;
  endfunction

endpackage

// File: rtl/vec_simd_engine_if.sv
// Beat-level streaming bus of the vector SIMD engine: operand A and B input
// streams and the result stream, each with a valid/ready handshake.
//   master : the streamer side (drives operands, accepts results)
//   slave  : the engine side
interface vec_simd_engine_if #(
  parameter int DATA_WIDTH = 8,
  parameter int LANES      = 4
);
  logic [LANES*DATA_WIDTH-1:0] a_data;
  logic                        a_valid;
  logic                        a_ready;
  logic [LANES*DATA_WIDTH-1:0] b_data;
  logic                        b_valid;
  logic                        b_ready;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic [LANES-1:0]            out_mask;
  logic                        out_valid;
  logic                        out_ready;

  modport master (
    output a_data, a_valid, b_data, b_valid, out_ready,
    input  a_ready, b_ready, out_data, out_mask, out_valid
  );

  modport slave (
    input  a_data, a_valid, b_data, b_valid, out_ready,
    output a_ready, b_ready, out_data, out_mask, out_valid
  );
endinterface

// File: rtl/vec_simd_engine_lane_alu.sv
// vec_lane_alu: one lane of the engine, purely combinational.
//   op             : opcode
//   a, b           : signed operands
//   imm_lo, imm_hi : SCALE factor / CLAMP bounds
//   y              : saturated DATA_WIDTH-bit result
module vec_lane_alu
  import vec_simd_engine_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_BITS  = 7
) (
  input  vec_op_t                       op,
  input  logic signed [DATA_WIDTH-1:0]  a,
  input  logic signed [DATA_WIDTH-1:0]  b,
  input  logic signed [DATA_WIDTH-1:0]  imm_lo,
  input  logic signed [DATA_WIDTH-1:0]  imm_hi,
  output logic signed [DATA_WIDTH-1:0]  y
);
  // Round-half-up constant added before the arithmetic right shift.
  localparam logic signed [31:0] RND = (FRAC_BITS > 0) ? (32'sd1 <<< (FRAC_BITS - 1)) : 32'sd0;

  logic signed [31:0] a32, b32, m32, wide;

  always_comb begin
    a32  = 32'(a);
    b32  = 32'(b);
    m32  = (op == OP_SCALE) ? 32'(imm_lo) : b32;
    wide = a32;
    case (op)
      OP_ADD:           wide = sat_signed(a32 + b32, DATA_WIDTH);
      OP_SUB:           wide = sat_signed(a32 - b32, DATA_WIDTH);
      OP_MUL, OP_SCALE: wide = sat_signed((a32 * m32 + RND) >>> FRAC_BITS, DATA_WIDTH);
      OP_CLAMP: begin
        if (a > imm_hi)      wide = 32'(imm_hi);
        else if (a < imm_lo) wide = 32'(imm_lo);
      end
      OP_MAX:           if (b > a) wide = b32;
      OP_RELU:          if (a < 0) wide = '0;
      default:          wide = a32;
    endcase
    y = wide[DATA_WIDTH-1:0];
  end
endmodule

// File: rtl/vec_simd_engine.sv
// vec_simd_engine: LANES-wide element-wise ALU with a two-stage pipeline.
//   clk, rst               : clock, synchronous active-high reset
//   start                  : command strobe (sampled only in IDLE)
//   operation              : opcode, latched at start
//   num_elements           : vector length, latched at start
//   imm_lo, imm_hi         : SCALE factor / CLAMP bounds, latched at start
//   busy, done             : command status; done pulses once per command
//   stream                 : A/B operand and result streams (slave side)
module vec_simd_engine
  import vec_simd_engine_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int LANES        = 4,
  parameter int MAX_ELEMENTS = 4096,
  parameter int FRAC_BITS    = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  vec_op_t                       operation,
  input  logic [$clog2(MAX_ELEMENTS):0] num_elements,
  input  logic [DATA_WIDTH-1:0]         imm_lo,
  input  logic [DATA_WIDTH-1:0]         imm_hi,
  output logic                          busy,
  output logic                          done,
  vec_simd_engine_if.slave              stream
);
  localparam int NW = $clog2(MAX_ELEMENTS) + 1;
  localparam int BW = LANES * DATA_WIDTH;

  vec_state_t            state;
  vec_op_t               op_r;
  logic [DATA_WIDTH-1:0] imm_lo_r, imm_hi_r;
  logic [NW-1:0]         beats_left;
  logic [LANES-1:0]      last_mask;

  logic                  s1_valid;
  logic [BW-1:0]         s1_a, s1_b;
  logic [LANES-1:0]      s1_mask;
  logic [BW-1:0]         alu_y;

  logic                  binary, advance, accept;

  assign binary  = is_binary(op_r);
  // Both stages move together; the result register frees up when empty or read.
  assign advance = !stream.out_valid || stream.out_ready;
  assign accept  = (state == ST_RUN) && stream.a_valid && (stream.b_valid || !binary) && advance;

  assign stream.a_ready = accept;
  assign stream.b_ready = accept && binary;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_lane_alu #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS)
    ) u_alu (
      .op     (op_r),
      .a      (s1_a[i*DATA_WIDTH +: DATA_WIDTH]),
      .b      (s1_b[i*DATA_WIDTH +: DATA_WIDTH]),
      .imm_lo (imm_lo_r),
      .imm_hi (imm_hi_r),
      .y      (alu_y[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      op_r             <= OP_NOP;
      imm_lo_r         <= '0;
      imm_hi_r         <= '0;
      beats_left       <= '0;
      last_mask        <= '0;
      s1_valid         <= 1'b0;
      s1_a             <= '0;
      s1_b             <= '0;
      s1_mask          <= '0;
      stream.out_valid <= 1'b0;
      stream.out_data  <= '0;
      stream.out_mask  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_r       <= operation;
            imm_lo_r   <= imm_lo;
            imm_hi_r   <= imm_hi;
            beats_left <= NW'((32'(num_elements) + 32'(LANES) - 32'd1) / 32'(LANES));
            last_mask  <= LANES'(low_mask(32'(num_elements) % 32'(LANES)));
            busy       <= 1'b1;
            if (num_elements == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            beats_left <= beats_left - 1'b1;
            if (beats_left == NW'(1)) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // Stage 1 empty and stage 2 either empty or being read this cycle.
          if (!s1_valid && advance) begin
            state <= ST_DONE;
            done  <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase

      if (advance) begin
        s1_valid <= accept;
        if (accept) begin
          s1_a    <= stream.a_data;
          s1_b    <= stream.b_data;
          s1_mask <= (beats_left == NW'(1)) ? last_mask : '1;
        end
        stream.out_valid <= s1_valid;
        if (s1_valid) begin
          stream.out_mask <= s1_mask;
          for (int unsigned i = 0; i < LANES; i++) begin
            stream.out_data[i*DATA_WIDTH +: DATA_WIDTH] <=
              s1_mask[i] ? alu_y[i*DATA_WIDTH +: DATA_WIDTH] : '0;
          end
        end
      end
    end
  end
endmodule
